pedal_blip_conditioner: RTL and testbench
=========================================

PEDAL_BLIP_CONDITIONER -- requirements
Module: pedal_blip_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50_000: clk50M cycles the raw input must hold a new level before it is accepted (1 ms).
REQ-002 Parameter MIN_PERIOD_CYCLES, default 2_500_000: minimum rising-edge-to-rising-edge spacing; shorter edges are rejected as noise (50 ms).
REQ-003 Parameter STALL_CYCLES, default 100_000_000: no accepted blip for this long means the cranks are stopped (2 s).
REQ-004 clk50M  input  1  system clock, 50 MHz; the block's only clock.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 pedal_raw  input  1  raw hall-sensor line from the crank; asynchronous to clk50M and bouncy.
REQ-007 blips  output  1  clean, debounced pedal level; the cadence counter consumes it.
REQ-008 blip_pulse  output  1  one-cycle strobe on each accepted rising edge.
REQ-009 period  output  28  clk50M cycles between the last two accepted rising edges.
REQ-010 period_valid  output  1  one-cycle strobe when period updates.
REQ-011 stalled  output  1  high while no blip has been accepted for STALL_CYCLES.

Function
REQ-012 pedal_raw shall pass through a 2-flop synchronizer; all later logic uses the second flop only.
REQ-013 Debounce FSM states shall be LOW, CONFIRM_HIGH, HIGH and CONFIRM_LOW.
- LOW->CONFIRM_HIGH when the synced input is 1.
- CONFIRM_HIGH->HIGH after DEBOUNCE_CYCLES consecutive 1s; back to LOW on any 0.
- HIGH and CONFIRM_LOW mirror this for the falling edge.
REQ-014 The debounce counter shall clear on every state entry.
REQ-015 blips shall be 1 in HIGH and CONFIRM_LOW and 0 in LOW and CONFIRM_HIGH.
- blips shall update on the cycle the FSM enters HIGH or LOW.
REQ-016 A 28-bit gap counter shall increment every cycle and saturate at 2^28-1; it shall never wrap.
REQ-017 When CONFIRM_HIGH->HIGH occurs and gap >= MIN_PERIOD_CYCLES (or this is the first edge since reset/stall), the edge is accepted:
- blip_pulse=1 on that same cycle;
- gap clears to 0 on the next cycle.
REQ-018 An edge with gap < MIN_PERIOD_CYCLES shall be rejected:
- FSM still goes to HIGH and blips still rises;
- no blip_pulse;
- gap is not cleared.
REQ-019 When an edge is accepted, not first, and stalled=0, period shall load the gap value and period_valid pulses for 1 cycle.
- The first accepted edge after reset or stall shall not produce period_valid.
REQ-020 stalled shall set on the cycle gap reaches STALL_CYCLES and clear on the next accepted edge.
REQ-021 If an accepted edge and the stall threshold fall on the same cycle, the accepted edge wins: stalled stays 0.
REQ-022 Latency from a clean pedal_raw rising edge to blip_pulse shall be DEBOUNCE_CYCLES+3 clocks.

Reset
REQ-023 Asserting reset_n low shall, immediately and with no clock:
- put the FSM in LOW and clear the synchronizer flops;
- set blips=0, blip_pulse=0, period=0, period_valid=0, stalled=1;
- clear the gap and debounce counters and set the first-edge flag.
REQ-024 Reset asserted mid-debounce or mid-period shall abandon the operation with no pulse.
REQ-025 Release shall be synchronous-safe: the first active edge is evaluated on the second clk50M after release.

Configuration
REQ-026 With macro BLIP_PERIOD_MEAS_EN defined, period and period_valid shall behave per REQ-019.
REQ-027 Without BLIP_PERIOD_MEAS_EN, period shall be tied to 0 and period_valid to 0, and the period register shall not be synthesized.
- The gap counter, rejection and stall logic shall remain.

Verification
(Bench parameters: DEBOUNCE_CYCLES=4, MIN_PERIOD_CYCLES=20, STALL_CYCLES=100.)
REQ-028 pedal_raw high for 3 cycles then low -> blips stays 0, no blip_pulse.
REQ-029 Clean rising edge after reset -> blip_pulse on cycle 7 after the edge; stalled 1->0; no period_valid.
REQ-030 Rising edges 50 cycles apart -> period=50 with period_valid on the second blip_pulse (macro defined); period=0, period_valid never high (macro undefined).
REQ-031 Second edge 10 cycles after an accepted one -> blips toggles, no blip_pulse; the next edge at 50 cycles from the accepted edge gives period=50.
REQ-032 No edges for 100 cycles after an accepted blip -> stalled=1 exactly at gap=100; the next edge gives blip_pulse but no period_valid.
REQ-033 reset_n low during CONFIRM_HIGH -> outputs immediately at reset values; no pulse after release until a fresh edge debounces.

Source files
------------

// File: rtl/pedal_blip_conditioner_if.sv
// Signal bundle for the crank hall-sensor conditioner.
// master: conditioner side; slave: sensor driver / cadence consumer side.
interface pedal_blip_conditioner_if;
    logic        pedal_raw;
    logic        blips;
    logic        blip_pulse;
    logic [27:0] period;
    logic        period_valid;
    logic        stalled;

    modport master (
        input  pedal_raw,
        output blips, blip_pulse, period, period_valid, stalled
    );

    modport slave (
        output pedal_raw,
        input  blips, blip_pulse, period, period_valid, stalled
    );
endinterface

// File: rtl/pedal_blip_conditioner.sv
// Crank hall-sensor conditioner: sync, debounce, edge gating, stall detect.
// Optional period measurement is enabled by defining BLIP_PERIOD_MEAS_EN.
module pedal_blip_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES   = 50_000,
    parameter int unsigned MIN_PERIOD_CYCLES = 2_500_000,
    parameter int unsigned STALL_CYCLES      = 100_000_000
) (
    input  logic                     clk50M,
    input  logic                     reset_n,
    pedal_blip_conditioner_if.master bus
);
    typedef enum logic [1:0] {
        LOW,
        CONFIRM_HIGH,
        HIGH,
        CONFIRM_LOW
    } state_e;

    localparam int            CW        = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [27:0]   GAP_MAX   = '1;
    localparam logic [27:0]   MIN_GAP   = 28'(MIN_PERIOD_CYCLES);
    localparam logic [27:0]   STALL_GAP = 28'(STALL_CYCLES);

    logic          sync1_q, sync2_q;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          blips_q, blips_d;
    logic          pulse_q, pulse_d;
    logic [27:0]   gap_q, gap_d, gap_inc;
    logic          stalled_q, stalled_d;
    logic          rise, accept;

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        rise    = 1'b0;
        unique case (state_q)
            LOW: begin
                if (sync2_q) state_d = CONFIRM_HIGH;
            end
            CONFIRM_HIGH: begin
                if (!sync2_q) begin
                    state_d = LOW;
                end else if (cnt_q == DB_LAST) begin
                    state_d = HIGH;
                    rise    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HIGH: begin
                if (!sync2_q) state_d = CONFIRM_LOW;
            end
            CONFIRM_LOW: begin
                if (sync2_q) begin
                    state_d = HIGH;
                end else if (cnt_q == DB_LAST) begin
                    state_d = LOW;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
        blips_d = (state_d == HIGH) || (state_d == CONFIRM_LOW);
    end

    always_comb begin
        gap_inc   = (gap_q == GAP_MAX) ? gap_q : gap_q + 28'd1;
        // stalled_q doubles as the first-edge flag: reset and stall both set it
        accept    = rise && (stalled_q || (gap_inc >= MIN_GAP));
        pulse_d   = accept;
        gap_d     = accept ? '0 : gap_inc;
        stalled_d = stalled_q;
        if (accept) begin
            stalled_d = 1'b0;
        end else if (gap_inc == STALL_GAP) begin
            stalled_d = 1'b1;
        end
    end

    always_ff @(posedge clk50M or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            state_q   <= LOW;
            cnt_q     <= '0;
            blips_q   <= 1'b0;
            pulse_q   <= 1'b0;
            gap_q     <= '0;
            stalled_q <= 1'b1;
        end else begin
            sync1_q   <= bus.pedal_raw;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            blips_q   <= blips_d;
            pulse_q   <= pulse_d;
            gap_q     <= gap_d;
            stalled_q <= stalled_d;
        end
    end

    assign bus.blips      = blips_q;
    assign bus.blip_pulse = pulse_q;
    assign bus.stalled    = stalled_q;

`ifdef BLIP_PERIOD_MEAS_EN
    logic [27:0] period_q, period_d;
    logic        pv_q, pv_d;

    always_comb begin
        pv_d     = accept && !stalled_q;
        period_d = pv_d ? gap_inc : period_q;
    end

    always_ff @(posedge clk50M or negedge reset_n) begin
        if (!reset_n) begin
            period_q <= '0;
            pv_q     <= 1'b0;
        end else begin
            period_q <= period_d;
            pv_q     <= pv_d;
        end
    end

    assign bus.period       = period_q;
    assign bus.period_valid = pv_q;
`else
    assign bus.period       = '0;
    assign bus.period_valid = 1'b0;
`endif
endmodule

// File: tb/tb_pedal_blip_conditioner.sv
// Self-checking bench for pedal_blip_conditioner against a sample-history model.
// Build with or without BLIP_PERIOD_MEAS_EN; expectations follow the macro.
module tb_pedal_blip_conditioner;
  localparam int D     = 4;
  localparam int MINP  = 20;
  localparam int STALL = 100;
  localparam logic [31:0] RST_V = {4'b0001, 28'd0};

  logic clk50M  = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int errors = 0;

  pedal_blip_conditioner_if bus();

  pedal_blip_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .MIN_PERIOD_CYCLES(MINP),
    .STALL_CYCLES(STALL)
  ) dut (
    .clk50M(clk50M),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk50M = ~clk50M;

  // reference model: level flips once D+1 consecutive synced samples disagree
  bit          hist[$];
  bit          lvl = 0, first = 1;
  bit          m_pulse = 0, m_pv = 0, m_stalled = 1;
  logic [27:0] m_period = '0;
  int          cyc = 0, last_acc = 0, run = 0, el = 0;
  bit          samp, acc;

  always @(posedge clk50M or negedge reset_n) begin
    if (!reset_n) begin
      hist.delete();
      lvl = 0; first = 1; run = 0;
      m_pulse = 0; m_pv = 0; m_stalled = 1; m_period = '0;
      cyc = 0; last_acc = 0;
    end else begin
      hist.push_back(bus.pedal_raw);
      if (hist.size() > 4) void'(hist.pop_front());
      samp = (hist.size() >= 3) ? hist[hist.size()-3] : 1'b0;
      cyc++;
      el = cyc - last_acc;
      m_pulse = 0; m_pv = 0; acc = 0;
      if (samp != lvl) run++;
      else run = 0;
      if (run == D + 1) begin
        lvl = ~lvl;
        run = 0;
        if (lvl && (first || el >= MINP)) acc = 1;
      end
      if (acc) begin
        m_pulse = 1;
`ifdef BLIP_PERIOD_MEAS_EN
        if (!first && !m_stalled) begin
          m_pv = 1;
          m_period = 28'(el);
        end
`endif
        first = 0; m_stalled = 0; last_acc = cyc;
      end else if (el == STALL) begin
        m_stalled = 1; first = 1;
      end
    end
  end

  wire [31:0] dut_v = {bus.blips, bus.blip_pulse, bus.period_valid,
                       bus.stalled, bus.period};
  wire [31:0] mdl_v = {lvl, m_pulse, m_pv, m_stalled, m_period};

  task automatic tick(input bit v);
    bus.pedal_raw = v;
    @(posedge clk50M);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.pedal_raw = 1'b0;
    repeat (3) @(posedge clk50M);
    #1;
    checks++;
    if (dut_v !== RST_V) begin
      errors++;
      $display("FAIL reset_state got %h exp %h", dut_v, RST_V);
    end
    checks++;
    if (dut_v !== mdl_v) begin
      errors++;
      $display("FAIL reset_model got %h exp %h", dut_v, mdl_v);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_glitch();
    bit seen = 0;
    for (int i = 0; i < 15; i++) begin
      tick(i < 3);
      checks++;
      if (dut_v !== mdl_v) begin
        errors++;
        $display("FAIL glitch cyc %0d got %h exp %h", i, dut_v, mdl_v);
      end
      if (bus.blips || bus.blip_pulse) seen = 1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL glitch_quiet got %0d exp 0", seen);
    end
  endtask

  task automatic test_first_edge();
    int at = -1;
    bit pv_seen = 0;
    for (int i = 1; i <= 22; i++) begin
      tick(i <= 12);
      checks++;
      if (dut_v !== mdl_v) begin
        errors++;
        $display("FAIL first_edge cyc %0d got %h exp %h", i, dut_v, mdl_v);
      end
      if (bus.blip_pulse && at < 0) at = i;
      if (bus.period_valid) pv_seen = 1;
    end
    checks++;
    if (at != D + 3) begin
      errors++;
      $display("FAIL latency got %0d exp %0d", at, D + 3);
    end
    checks++;
    if (bus.stalled !== 1'b0 || pv_seen) begin
      errors++;
      $display("FAIL first_edge_flags stalled %b pv %0d exp 0 0",
               bus.stalled, pv_seen);
    end
  endtask

  task automatic test_period();
    int lv[4] = '{1, 0, 1, 0};
    int ln[4] = '{10, 40, 10, 20};
    int pulses = 0;
    bit pv_any = 0;
    logic [27:0] lastp = '0;
    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < ln[s]; k++) begin
        tick(lv[s] != 0);
        checks++;
        if (dut_v !== mdl_v) begin
          errors++;
          $display("FAIL period seg %0d got %h exp %h", s, dut_v, mdl_v);
        end
        if (bus.blip_pulse) pulses++;
        if (bus.period_valid) begin
          pv_any = 1;
          lastp = bus.period;
        end
      end
    end
    checks++;
    if (pulses != 2) begin
      errors++;
      $display("FAIL period_pulses got %0d exp 2", pulses);
    end
    checks++;
`ifdef BLIP_PERIOD_MEAS_EN
    if (lastp !== 28'd50 || !pv_any) begin
      errors++;
      $display("FAIL period_value got %0d pv %0d exp 50 1", lastp, pv_any);
    end
`else
    if (pv_any || bus.period !== 28'd0) begin
      errors++;
      $display("FAIL period_tied got %0d pv %0d exp 0 0", bus.period, pv_any);
    end
`endif
  endtask

  task automatic test_reject();
    int lv[6] = '{1, 0, 1, 0, 1, 0};
    int ln[6] = '{5, 5, 5, 35, 10, 20};
    int pulses = 0, rises = 0;
    bit pb = bus.blips;
    bit pv_any = 0;
    logic [27:0] lastp = '0;
    for (int s = 0; s < 6; s++) begin
      for (int k = 0; k < ln[s]; k++) begin
        tick(lv[s] != 0);
        checks++;
        if (dut_v !== mdl_v) begin
          errors++;
          $display("FAIL reject seg %0d got %h exp %h", s, dut_v, mdl_v);
        end
        if (bus.blip_pulse) pulses++;
        if (bus.blips && !pb) rises++;
        pb = bus.blips;
        if (bus.period_valid) begin
          pv_any = 1;
          lastp = bus.period;
        end
      end
    end
    checks++;
    if (pulses != 2 || rises != 3) begin
      errors++;
      $display("FAIL reject_counts pulses %0d rises %0d exp 2 3", pulses, rises);
    end
    checks++;
`ifdef BLIP_PERIOD_MEAS_EN
    if (lastp !== 28'd50) begin
      errors++;
      $display("FAIL reject_period got %0d exp 50", lastp);
    end
`else
    if (pv_any || lastp !== 28'd0) begin
      errors++;
      $display("FAIL reject_period_tied got %0d pv %0d exp 0 0", lastp, pv_any);
    end
`endif
  endtask

  task automatic test_stall();
    int p = -1, st = -1;
    bit pulse2 = 0, pv2 = 0;
    for (int i = 1; i <= 130; i++) begin
      tick(i <= 8);
      checks++;
      if (dut_v !== mdl_v) begin
        errors++;
        $display("FAIL stall cyc %0d got %h exp %h", i, dut_v, mdl_v);
      end
      if (bus.blip_pulse && p < 0) p = i;
      if (p > 0 && st < 0 && bus.stalled) st = i;
    end
    checks++;
    if (p < 0 || st - p != STALL) begin
      errors++;
      $display("FAIL stall_time got %0d exp %0d", st - p, STALL);
    end
    for (int i = 1; i <= 25; i++) begin
      tick(i <= 12);
      checks++;
      if (dut_v !== mdl_v) begin
        errors++;
        $display("FAIL stall_exit cyc %0d got %h exp %h", i, dut_v, mdl_v);
      end
      if (bus.blip_pulse) pulse2 = 1;
      if (bus.period_valid) pv2 = 1;
    end
    checks++;
    if (!pulse2 || pv2 || bus.stalled !== 1'b0) begin
      errors++;
      $display("FAIL stall_exit_flags pulse %0d pv %0d st %b exp 1 0 0",
               pulse2, pv2, bus.stalled);
    end
  endtask

  task automatic test_tie();
    int p1 = -1, p2 = -1;
    bit st_seen = 0;
    logic [27:0] lastp = '0;
    for (int i = 1; i <= 120; i++) begin
      tick((i <= 8) || (i >= 101 && i <= 110));
      checks++;
      if (dut_v !== mdl_v) begin
        errors++;
        $display("FAIL tie cyc %0d got %h exp %h", i, dut_v, mdl_v);
      end
      if (bus.blip_pulse) begin
        if (p1 < 0) p1 = i;
        else p2 = i;
      end
      if (bus.stalled) st_seen = 1;
      if (bus.period_valid) lastp = bus.period;
    end
    checks++;
    if (p1 < 0 || p2 - p1 != STALL || st_seen) begin
      errors++;
      $display("FAIL tie_edge_wins gap %0d stalled %0d exp %0d 0",
               p2 - p1, st_seen, STALL);
    end
`ifdef BLIP_PERIOD_MEAS_EN
    checks++;
    if (lastp !== 28'(STALL)) begin
      errors++;
      $display("FAIL tie_period got %0d exp %0d", lastp, STALL);
    end
`endif
  endtask

  task automatic test_reset_mid();
    int pulses = 0, at = -1;
    for (int i = 1; i <= 4; i++) tick(1);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (dut_v !== RST_V) begin
      errors++;
      $display("FAIL reset_async got %h exp %h", dut_v, RST_V);
    end
    bus.pedal_raw = 1'b0;
    repeat (2) @(posedge clk50M);
    #1;
    reset_n = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      tick(0);
      checks++;
      if (dut_v !== mdl_v) begin
        errors++;
        $display("FAIL reset_idle cyc %0d got %h exp %h", i, dut_v, mdl_v);
      end
      if (bus.blip_pulse) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL reset_no_pulse got %0d exp 0", pulses);
    end
    for (int i = 1; i <= 20; i++) begin
      tick(i <= 10);
      checks++;
      if (dut_v !== mdl_v) begin
        errors++;
        $display("FAIL reset_fresh cyc %0d got %h exp %h", i, dut_v, mdl_v);
      end
      if (bus.blip_pulse && at < 0) at = i;
    end
    checks++;
    if (at != D + 3) begin
      errors++;
      $display("FAIL reset_fresh_latency got %0d exp %0d", at, D + 3);
    end
  endtask

  task automatic test_random();
    bit v = 0;
    int len;
    for (int s = 0; s < 80; s++) begin
      v = $urandom_range(0, 1);
      len = ($urandom_range(0, 9) == 0) ? 110 : $urandom_range(1, 12);
      for (int k = 0; k < len; k++) begin
        tick(v);
        checks++;
        if (dut_v !== mdl_v) begin
          errors++;
          $display("FAIL random seg %0d got %h exp %h", s, dut_v, mdl_v);
        end
      end
    end
  endtask

  initial begin
    bus.pedal_raw = 1'b0;
    test_reset();
    test_glitch();
    test_first_edge();
    test_period();
    test_reject();
    test_stall();
    test_tie();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
